// File: rtl/rf_ctl_pkg.sv
// Shared types and widths for the register-file writeback control path.
// Holds the FSM state enum and the address, data and starvation widths.
package rf_ctl_pkg;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int SW = 2;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } rf_state_e;

endpackage

// File: rtl/rf_wb_prio.sv
// Writeback grant logic: mem wins by default, and the ALU is forced through
// once it has been denied STARVE_LIMIT times in a row.
module rf_wb_prio
  import rf_ctl_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          alu_valid,
  input  logic          mem_valid,
  output logic          alu_ready,
  output logic          mem_ready,
  output logic [SW-1:0] starve_cnt
);

  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

  logic force_alu;

  always_comb begin
    force_alu = alu_valid && (starve_cnt == LIM);
    alu_ready = run && alu_valid && (force_alu || !mem_valid);
    mem_ready = run && mem_valid && !alu_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (alu_ready) begin
      starve_cnt <= '0;
    end else if (run && alu_valid && starve_cnt != LIM) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter with optional init sequencer.
// Define RF_WB_INIT_SEQ_EN to clear the file and preset SP_INDEX after reset.
module rf_wb_arbiter
  import rf_ctl_pkg::*;
#(
  parameter int          STARVE_LIMIT = 3,
  parameter int          SP_INDEX     = 16,
  parameter logic [31:0] SP_INIT      = 32'h17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_addr,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  output logic          mem_ready,
  output logic          we,
  output logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          init_busy,
  output logic [SW-1:0] starve_cnt
);

  localparam logic [AW-1:0] SPI = AW'(SP_INDEX);

  rf_state_e     state;
  logic [AW-1:0] idx;
  logic          run;
  logic          alu_xfer;
  logic          mem_xfer;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;

`ifdef RF_WB_INIT_SEQ_EN
  localparam rf_state_e RST_ST = ST_INIT;
  assign init_busy = (state == ST_INIT);
`else
  localparam rf_state_e RST_ST = ST_RUN;
  assign init_busy = 1'b0;
`endif

  assign run = (state == ST_RUN) && !rst;

  rf_wb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .alu_valid (alu_valid),
    .mem_valid (mem_valid),
    .alu_ready (alu_ready),
    .mem_ready (mem_ready),
    .starve_cnt(starve_cnt)
  );

  always_comb begin
    alu_xfer = alu_valid && alu_ready;
    mem_xfer = mem_valid && mem_ready;
    w_addr   = alu_xfer ? alu_addr : mem_addr;
    w_data   = alu_xfer ? alu_data : mem_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RST_ST;
      idx     <= '0;
      we      <= 1'b0;
      rd_addr <= '0;
      rd_data <= '0;
    end else begin
      unique case (state)
        ST_INIT: begin
          we      <= 1'b1;
          rd_addr <= idx;
          rd_data <= (idx == SPI) ? SP_INIT : '0;
          idx     <= idx + 1'b1;
          if (idx == '1) state <= ST_RUN;
        end
        ST_RUN: begin
          we <= 1'b0;
          // x0 is hardwired: accept the handshake but never write it
          if ((alu_xfer || mem_xfer) && w_addr != '0) begin
            we      <= 1'b1;
            rd_addr <= w_addr;
            rd_data <= w_data;
          end
        end
        default: state <= RST_ST;
      endcase
    end
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3: consecutive denied ALU cycles before ALU is forced priority.
REQ-002 SHALL have parameter SP_INDEX, default 16: register preset during init ($s0).
REQ-003 SHALL have parameter SP_INIT, default 32'h17: value written to SP_INDEX during init.
REQ-004 SHALL have port clk  in  1: single clock; all state on posedge.
REQ-005 SHALL have port rst  in  1: reset, synchronous and active-high.
REQ-006 SHALL have ports alu_valid in 1, alu_addr in 5, alu_data in 32, alu_ready out 1: ALU writeback requester.
REQ-007 SHALL have ports mem_valid in 1, mem_addr in 5, mem_data in 32, mem_ready out 1: load writeback requester.
REQ-008 SHALL have ports we out 1, rd_addr out 5, rd_data out 32: register-file write port drive.
REQ-009 SHALL have port init_busy  out  1: high while the init sequence owns the write port.
REQ-010 SHALL have port starve_cnt  out  2: current ALU starvation count (observability).

Function
REQ-011 SHALL implement FSM states INIT and RUN; a transfer occurs on a requester when valid and ready are both high in the same cycle.
REQ-012 In INIT, SHALL step a 5-bit index 0..31, one per cycle, driving we=1, rd_addr=index, rd_data=0, except index SP_INDEX gets SP_INIT.
REQ-013 After index 31, SHALL enter RUN on the next cycle; INIT lasts exactly 32 cycles.
REQ-014 In INIT, SHALL hold alu_ready=mem_ready=0.
REQ-015 In RUN, SHALL grant at most one requester per cycle; ready is combinational from valids and starvation state.
REQ-016 Default priority: mem over alu.
REQ-017 When alu_valid=1 and the ALU is denied, SHALL increment starve_cnt, saturating at STARVE_LIMIT.
REQ-018 When starve_cnt==STARVE_LIMIT and alu_valid=1, SHALL grant the ALU over mem for that cycle.
REQ-019 Any ALU transfer SHALL clear starve_cnt to 0.
REQ-020 A transfer SHALL appear on we/rd_addr/rd_data registered, one cycle after the handshake cycle.
REQ-021 A transfer to address 0 SHALL complete the handshake but produce we=0.
REQ-022 With no transfer, SHALL drive we=0 on the next cycle; rd_addr/rd_data hold their last value.
REQ-023 Requesters SHALL hold valid, addr and data stable until ready; the block does not buffer denied requests.

Reset
REQ-024 rst SHALL force INIT with index=0, starve_cnt=0, we=0, rd_addr=0, rd_data=0, init_busy=1, both readies 0.
REQ-025 rst asserted mid-INIT or mid-RUN SHALL restart INIT from index 0 and drop any registered pending write.

Configuration
REQ-026 With RF_WB_INIT_SEQ_EN defined, SHALL implement INIT as in REQ-012..014 and REQ-024.
REQ-027 Without RF_WB_INIT_SEQ_EN, SHALL reset directly into RUN, tie init_busy=0, and issue no writes from reset.

Structure
REQ-028 SHALL place the FSM state enum (INIT, RUN), the register-address width (5) and the data width (32) in the shared package rf_ctl_pkg.
REQ-029 SHALL contain the grant and starvation logic in one sub-module, rf_wb_prio.
REQ-030 The init sequencer and output register SHALL stay in the top module.

Verification
REQ-031 Reset, then idle 32 cycles -> we=1 every cycle, addrs 0..31; addr 16 data 32'h17, others 0; then init_busy=0.
REQ-032 RUN: mem_valid and alu_valid both held high -> mem granted 3 cycles, ALU granted on the 4th, starve_cnt returns to 0.
REQ-033 RUN: alu_valid, alu_addr=5, alu_data=32'hDEAD -> alu_ready=1 same cycle; next cycle we=1, rd_addr=5, rd_data=32'hDEAD.
REQ-034 RUN: mem_valid, mem_addr=0 -> mem_ready=1, next cycle we=0.
REQ-035 Assert rst at INIT index 10 -> index restarts at 0; full 32-cycle INIT repeats.
REQ-036 Build without RF_WB_INIT_SEQ_EN -> after rst, init_busy=0, we=0, and a request is granted on the first cycle.
